rv_mem_arbiter: RTL and testbench

Single-port memory arbiter for the RV_CPU core. It shares one synchronous-read instruction/data memory between the instruction-fetch stage (IF) and the load/store stage (LS). Data accesses have fixed priority, and an optional starvation guard bounds fetch stall time. It sits between the core pipeline and the memory macro, and is the only block driving the memory port.

---
 rtl/rv_mem_arbiter_if.sv | 44 ++++
 rtl/rv_mem_arbiter.sv | 112 +++++++++++
 tb/tb_rv_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rv_mem_arbiter_if.sv
// Shared memory port bundle: IF and LS requester channels plus the single memory port.
// master = requesters and memory macro; slave = rv_mem_arbiter.
interface rv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Single-port memory arbiter: LS over IF fixed priority, registered read-return routing.
// Define ARB_STARVE_GUARD_EN to grant IF after MAX_WAIT consecutive stalled request cycles.
module rv_mem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rv_mem_arbiter_if.slave        bus,
  output logic [15:0]            conflict_cnt
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gen_bad_max_wait
    $error("MAX_WAIT must be in 1..15");
  end

  logic if_gnt, ls_gnt;
  logic starve;
  logic both_req;

  assign both_req = bus.if_req & bus.ls_req;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wait_q, wait_d;

  assign starve = (wait_q == 4'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (!bus.if_req || if_gnt) begin
      wait_d = 4'd0;
    end else if (wait_q != 4'(MAX_WAIT)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (bus.ls_req && !(bus.if_req && starve)) begin
        ls_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_en    = if_gnt | ls_gnt;
  assign bus.mem_we    = ls_gnt & bus.ls_we;
  assign bus.mem_wdata = bus.ls_wdata;
  assign bus.mem_addr  = ls_gnt ? bus.ls_addr : (if_gnt ? bus.if_addr : {ADDR_W{1'b0}});

  // Read-return tracking: owner_q = 1 means the outstanding read belongs to LS.
  logic rd_valid_q, rd_valid_d;
  logic owner_q, owner_d;

  always_comb begin
    rd_valid_d = bus.mem_en & ~bus.mem_we;
    owner_d    = ls_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      owner_q    <= owner_d;
    end
  end

  assign bus.if_rvalid = ~reset & rd_valid_q & ~owner_q;
  assign bus.ls_rvalid = ~reset & rd_valid_q & owner_q;
  assign bus.if_rdata  = ~owner_q ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.ls_rdata  = owner_q  ? bus.mem_rdata : {DATA_W{1'b0}};

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (both_req && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = reset ? 16'd0 : cnt_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed self-checking bench for rv_mem_arbiter with a behavioural synchronous memory.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] conflict_cnt;
  int          errors = 0;
  int          checks = 0;

  rv_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  rv_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as 0xA500_0000 | address.
  bit [31:0] mem [1024];
  bit        wr  [1024];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= wr[bus.mem_addr] ? mem[bus.mem_addr]
                                          : (32'hA500_0000 | 32'(bus.mem_addr));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
  endtask

  logic [5:0] exp_if_seq;

  initial begin
    reset = 1'b1;
    idle();
    bus.mem_rdata = '0;
`ifdef ARB_STARVE_GUARD_EN
    exp_if_seq = 6'b010000;
`else
    exp_if_seq = 6'b000000;
`endif

    // Reset with both requests active: everything quiet, counter held at 0.
    next_cycle();
    bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.if_addr = 10'h004; bus.ls_addr = 10'h008;
    #1;
    check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rst_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    next_cycle();
    #1;
    check("rst_conflict", 32'(conflict_cnt), 32'd0);
    check("rst_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();
    #1;
    check("idle_mem_en", 32'(bus.mem_en), 32'd0);

    // Single fetch.
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 10'h004;
    #1;
    check("fetch_if_gnt", 32'(bus.if_gnt), 32'd1);
    check("fetch_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    check("fetch_mem_en", 32'(bus.mem_en), 32'd1);
    check("fetch_mem_addr", 32'(bus.mem_addr), 32'h004);
    check("fetch_mem_we", 32'(bus.mem_we), 32'd0);
    next_cycle();
    idle();
    #1;
    check("fetch_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("fetch_if_rdata", bus.if_rdata, 32'hA500_0004);
    check("fetch_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
    check("fetch_idle_addr", 32'(bus.mem_addr), 32'd0);

    // Conflict: LS load wins, IF follows alone.
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 10'h008;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h100;
    #1;
    check("conf_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    check("conf_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("conf_mem_addr", 32'(bus.mem_addr), 32'h100);
    next_cycle();
    bus.ls_req = 1'b0;
    #1;
    check("conf_if_alone", 32'(bus.if_gnt), 32'd1);
    check("conf_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
    check("conf_ls_rdata", bus.ls_rdata, 32'hA500_0100);
    check("conf_if_rvalid0", 32'(bus.if_rvalid), 32'd0);
    check("conf_cnt", 32'(conflict_cnt), 32'd1);
    next_cycle();
    idle();
    #1;
    check("conf_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("conf_if_rdata", bus.if_rdata, 32'hA500_0008);

    // Store then load at the top address.
    next_cycle();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 10'h3FF; bus.ls_wdata = 32'hDEAD_BEEF;
    #1;
    check("st_mem_we", 32'(bus.mem_we), 32'd1);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_addr", 32'(bus.mem_addr), 32'h3FF);
    next_cycle();
    bus.ls_we = 1'b0;
    #1;
    check("ld_mem_we", 32'(bus.mem_we), 32'd0);
    check("ld_ls_gnt", 32'(bus.ls_gnt), 32'd1);
    check("st_no_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'd0);
    next_cycle();
    idle();
    #1;
    check("ld_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
    check("ld_ls_rdata", bus.ls_rdata, 32'hDEAD_BEEF);

    // Continuous contention for six cycles.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 10'h020;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h010;
      #1;
      check($sformatf("starve_if_gnt_c%0d", i), 32'(bus.if_gnt), 32'(exp_if_seq[i]));
      check($sformatf("starve_ls_gnt_c%0d", i), 32'(bus.ls_gnt), 32'(!exp_if_seq[i]));
    end
    next_cycle();
    idle();
    #1;
    check("starve_cnt", 32'(conflict_cnt), 32'd7);

    // Reset immediately after a granted read.
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 10'h004;
    #1;
    check("rr_if_gnt", 32'(bus.if_gnt), 32'd1);
    next_cycle();
    reset = 1'b1;
    bus.ls_req = 1'b1;
    #1;
    check("rr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rr_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
    check("rr_gnts", 32'({bus.if_gnt, bus.ls_gnt}), 32'd0);
    check("rr_conflict", 32'(conflict_cnt), 32'd0);
    check("rr_mem_en", 32'(bus.mem_en), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();

    // Saturation of the conflict counter.
    next_cycle();
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    repeat (65534) @(posedge clk);
    #2;
    check("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
    repeat (4466) @(posedge clk);
    #2;
    check("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
